// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the initiator state type.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic       HRESP_OKAY    = 1'b0;
    localparam logic       HRESP_ERROR   = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ADDR = 2'b01,
        DATA = 2'b10
    } state_e;

endpackage

// File: rtl/ahb_wait_timer.sv
// Counts consecutive stalled data-phase cycles; flags the cycle that reaches TIMEOUT.
module ahb_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (count_en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // The stall being counted now is the TIMEOUT-th one.
    assign expired = count_en && (cnt_q == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ahb_lite_master.sv
// Single-outstanding AHB-Lite initiator: one NONSEQ word transfer per command,
// with wait-state handling, error capture and a data-phase stall timeout.
module ahb_lite_master
    import ahb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] HADDR,
    output logic              HWRITE,
    output logic [1:0]        HTRANS,
    output logic [2:0]        HSIZE,
    output logic [DATA_W-1:0] HWDATA,
    input  logic [DATA_W-1:0] HRDATA,
    input  logic              HREADY,
    input  logic              HRESP
);

    state_e              state_q, state_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;
    logic [ADDR_W-1:0]   haddr_q, haddr_d;
    logic                hwrite_q, hwrite_d;
    logic [1:0]          htrans_q, htrans_d;
    logic [DATA_W-1:0]   hwdata_q, hwdata_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                timer_expired;

    ahb_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (state_q != DATA),
        .count_en ((state_q == DATA) && !HREADY),
        .expired  (timer_expired)
    );

    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        haddr_d     = haddr_q;
        hwrite_d    = hwrite_q;
        htrans_d    = htrans_q;
        hwdata_d    = hwdata_q;
        wdata_d     = wdata_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    haddr_d     = cmd_addr;
                    hwrite_d    = cmd_write;
                    wdata_d     = cmd_wdata;
                    htrans_d    = HTRANS_NONSEQ;
                    cmd_ready_d = 1'b0;
                    state_d     = ADDR;
                end
            end
            ADDR: begin
                // Address phase completes only once the previous data phase releases HREADY.
                if (HREADY) begin
                    htrans_d = HTRANS_IDLE;
                    if (hwrite_q) begin
                        hwdata_d = wdata_q;
                    end
                    state_d = DATA;
                end
            end
            DATA: begin
                if (HREADY) begin
                    rsp_valid_d = 1'b1;
                    if (!hwrite_q) begin
                        rsp_rdata_d = HRDATA;
                    end
                    rsp_err_d   = (HRESP == HRESP_ERROR);
                    cmd_ready_d = 1'b1;
                    state_d     = IDLE;
                end else if (timer_expired) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    cmd_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            haddr_q     <= '0;
            hwrite_q    <= 1'b0;
            htrans_q    <= HTRANS_IDLE;
            hwdata_q    <= '0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            haddr_q     <= haddr_d;
            hwrite_q    <= hwrite_d;
            htrans_q    <= htrans_d;
            hwdata_q    <= hwdata_d;
            wdata_q     <= wdata_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign HADDR     = haddr_q;
    assign HWRITE    = hwrite_q;
    assign HTRANS    = htrans_q;
    assign HSIZE     = HSIZE_WORD;
    assign HWDATA    = hwdata_q;

endmodule
